// File: rtl/scan_pkg.sv
// Shared types and constants for the scan shifter: FSM state encoding and
// the ASCII characters used on the command/response byte streams.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_BIT,
    CLK_LO,
    CLK_HI,
    PUT_BIT,
    FINISH
  } scan_state_e;

  localparam logic [7:0] CHAR_ZERO = 8'h30;
  localparam logic [7:0] CHAR_ONE  = 8'h31;

  function automatic logic [7:0] bit_to_char(input logic b);
    return b ? CHAR_ONE : CHAR_ZERO;
  endfunction

endpackage

// File: rtl/scan_shifter_if.sv
// Valid/ready byte stream used for both the parser-side input and the
// uart_tx-side output of the scan shifter.
interface scan_shifter_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/scan_clk_gen.sv
// Part-clock timing: after a start pulse, CLK_DIV cycles low phase then
// CLK_DIV cycles high phase; phase doubles as a registered part_clk.
module scan_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic phase,
  output logic half_end,
  output logic pulse_end
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             active;

  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      phase   <= 1'b0;
      div_cnt <= '0;
    end else if (start) begin
      active  <= 1'b1;
      phase   <= 1'b0;
      div_cnt <= '0;
    end else if (active) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        phase   <= !phase;
        if (phase) active <= 1'b0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign half_end  = active && (div_cnt == DIV_LAST);
  assign pulse_end = half_end && phase;

endmodule

// File: rtl/scan_shifter.sv
// ASCII-driven scan-chain loader/unloader for the CSOC test port.
// Optional SCAN_RECIRC_EN feeds unloaded bits back into part_scan_in.
module scan_shifter
  import scan_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             unload_start,
  input  logic [CNT_W-1:0] bit_count,
  scan_shifter_if.slave    in_s,
  scan_shifter_if.master   out_s,
  output logic             part_clk,
  output logic             part_test_se,
  output logic             part_test_tm,
  output logic             part_scan_in,
  input  logic             part_scan_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  scan_state_e      state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             load_mode;
  logic             scan_bit;
  logic [7:0]       out_data_r;
  logic             shift_go;
  logic             half_end, pulse_end;

  scan_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .start     (shift_go),
    .phase     (part_clk),
    .half_end  (half_end),
    .pulse_end (pulse_end)
  );

  // A zero count parks in GET_BIT/PUT_BIT for one cycle so FINISH lands
  // two cycles after the start without ever offering a handshake.
  always_comb begin
    state_nx = state;
    shift_go = 1'b0;
    case (state)
      IDLE: begin
        if (load_start)        state_nx = GET_BIT;
        else if (unload_start) state_nx = PUT_BIT;
      end
      GET_BIT: begin
        if (cnt == '0) state_nx = FINISH;
        else if (in_s.valid) begin
          state_nx = CLK_LO;
          shift_go = 1'b1;
        end
      end
      PUT_BIT: begin
        if (cnt == '0) state_nx = FINISH;
        else if (out_s.ready) begin
          state_nx = CLK_LO;
          shift_go = 1'b1;
        end
      end
      CLK_LO: if (half_end) state_nx = CLK_HI;
      CLK_HI: begin
        if (pulse_end) begin
          if (cnt == CNT_W'(1)) state_nx = FINISH;
          else                  state_nx = load_mode ? GET_BIT : PUT_BIT;
        end
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      load_mode  <= 1'b0;
      scan_bit   <= 1'b0;
      out_data_r <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (load_start || unload_start)) begin
        cnt       <= bit_count;
        load_mode <= load_start;
        err       <= 1'b0;
      end
      if (state == GET_BIT && shift_go) begin
        scan_bit <= (in_s.data == CHAR_ONE);
        if (in_s.data != CHAR_ONE && in_s.data != CHAR_ZERO) err <= 1'b1;
      end
      if (state_nx == PUT_BIT && state != PUT_BIT) begin
        scan_bit   <= part_scan_out;
        out_data_r <= bit_to_char(part_scan_out);
      end
      if (state == CLK_HI && pulse_end) cnt <= cnt - 1'b1;
    end
  end

  assign busy         = (state != IDLE) && (state != FINISH);
  assign done         = (state == FINISH);
  assign part_test_se = busy;
  assign part_test_tm = busy;
  assign in_s.ready   = (state == GET_BIT) && (cnt != '0);
  assign out_s.valid  = (state == PUT_BIT) && (cnt != '0);
  assign out_s.data   = out_data_r;

`ifdef SCAN_RECIRC_EN
  assign part_scan_in = (state != IDLE) && scan_bit;
`else
  assign part_scan_in = (state != IDLE) && load_mode && scan_bit;
`endif

endmodule

// File: tb/tb_scan_shifter.sv
// Directed + randomized bench for scan_shifter with a bit-queue chain model.
module tb_scan_shifter;

`ifdef SCAN_RECIRC_EN
  localparam bit RECIRC = 1'b1;
`else
  localparam bit RECIRC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0, unload_start = 1'b0;
  logic [15:0] bit_count = '0;
  logic        part_clk, part_test_se, part_test_tm, part_scan_in, part_scan_out;
  logic        busy, done, err;

  scan_shifter_if in_s ();
  scan_shifter_if out_s ();

  scan_shifter #(.CLK_DIV(3), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_start    (load_start),
    .unload_start  (unload_start),
    .bit_count     (bit_count),
    .in_s          (in_s),
    .out_s         (out_s),
    .part_clk      (part_clk),
    .part_test_se  (part_test_se),
    .part_test_tm  (part_test_tm),
    .part_scan_in  (part_scan_in),
    .part_scan_out (part_scan_out),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  int unsigned n_assert = 0, n_fail = 0;

  // Chain model: shifts on each observed rising part_clk, tap at MSB.
  logic [31:0] chain = '0, seed = '0;
  int unsigned chain_len = 8;
  bit          seed_stb = 0, seed_ack = 0;
  int unsigned edge_cnt = 0, hold_viol = 0;
  logic        edge_bits[$];
  logic        prev_pclk = 1'b0, hi_bit = 1'b0;

  assign part_scan_out = chain[chain_len-1];

  always @(negedge clk) begin
    if (seed_stb != seed_ack) begin
      chain = seed;
      edge_cnt = 0;
      hold_viol = 0;
      edge_bits.delete();
      seed_ack = seed_stb;
    end else if (part_clk && !prev_pclk) begin
      edge_bits.push_back(part_scan_in);
      hi_bit = part_scan_in;
      chain = {chain[30:0], part_scan_in} & ((32'h1 << chain_len) - 32'h1);
      edge_cnt++;
    end else if (part_clk && part_scan_in !== hi_bit) begin
      hold_viol++;
    end
    prev_pclk = part_clk;
  end

  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  int unsigned done_cnt, done_cyc;
  bit          saw_in_ready, saw_out_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reseed(input logic [31:0] val, input int unsigned len);
    chain_len = len;
    seed = val;
    seed_stb = !seed_stb;
  endtask

  task automatic run_op(input bit is_load, input int unsigned n, input bit rnd, input int stall_at);
    int unsigned cyc, bad, e0;
    bit fin;
    logic [7:0] held;
    rx_q.delete();
    done_cnt = 0; done_cyc = 0; saw_in_ready = 0; saw_out_valid = 0;
    @(negedge clk);
    bit_count = 16'(n);
    load_start = is_load;
    unload_start = !is_load;
    cyc = 0; fin = 0;
    while (!fin && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      load_start = 1'b0;
      unload_start = 1'b0;
      if (cyc == 1) check("active_after_start", {busy, part_test_tm, part_test_se}, 3'b111);
      // opposite start mid-operation must be ignored
      if (cyc == 4) begin
        load_start = !is_load;
        unload_start = is_load;
      end
      if (in_s.ready) saw_in_ready = 1;
      if (out_s.valid) saw_out_valid = 1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        fin = 1;
      end
      if (stall_at >= 0 && out_s.valid && rx_q.size() == stall_at) begin
        out_s.ready = 1'b0;
        held = out_s.data;
        e0 = edge_cnt;
        bad = 0;
        repeat (50) begin
          @(negedge clk);
          cyc++;
          if (!(out_s.valid === 1'b1 && out_s.data === held)) bad++;
        end
        check("stall_out_stable", bad, 0);
        check("stall_no_edge", edge_cnt, e0);
        stall_at = -1;
      end
      in_s.valid = (tx_q.size() != 0) && (!rnd || $urandom_range(0, 2) != 0);
      in_s.data = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
      out_s.ready = !rnd || ($urandom_range(0, 1) == 1);
      if (in_s.valid && in_s.ready) void'(tx_q.pop_front());
      if (out_s.valid && out_s.ready) rx_q.push_back(out_s.data);
    end
    in_s.valid = 1'b0;
    out_s.ready = 1'b0;
    check("op_timeout", fin, 1);
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("done_once", done_cnt, 1);
    check("idle_after", {busy, part_test_se, part_test_tm, part_clk, in_s.ready, out_s.valid}, 0);
  endtask

  task automatic check_load(input string tag, input logic [7:0] bytes[$]);
    logic [31:0] exp_w, obs_w;
    bit exp_err;
    exp_w = '0; obs_w = '0; exp_err = 0;
    foreach (bytes[i]) begin
      exp_w = (exp_w << 1) | 32'(bytes[i] == 8'h31);
      if (bytes[i] != 8'h31 && bytes[i] != 8'h30) exp_err = 1;
    end
    foreach (edge_bits[i]) obs_w = (obs_w << 1) | 32'(edge_bits[i]);
    check({tag, "_edges"}, edge_cnt, bytes.size());
    check({tag, "_bits"}, obs_w, exp_w);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_hold"}, hold_viol, 0);
    check({tag, "_no_out"}, saw_out_valid, 0);
  endtask

  task automatic check_unload(input string tag, input logic [31:0] c0, input int unsigned len,
                              input int unsigned n);
    logic q[$];
    logic b;
    logic [31:0] exp_chain;
    logic [7:0] exp_rx[$];
    for (int unsigned i = 0; i < len; i++) q.push_back(c0[len-1-i]);
    for (int unsigned i = 0; i < n; i++) begin
      b = q.pop_front();
      exp_rx.push_back(b ? 8'h31 : 8'h30);
      q.push_back(RECIRC ? b : 1'b0);
    end
    exp_chain = '0;
    foreach (q[i]) exp_chain = (exp_chain << 1) | 32'(q[i]);
    check({tag, "_count"}, rx_q.size(), n);
    for (int unsigned i = 0; i < n && i < rx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_rx[i]);
    check({tag, "_edges"}, edge_cnt, n);
    check({tag, "_chain"}, chain, exp_chain);
    check({tag, "_err"}, err, 0);
    check({tag, "_no_in"}, saw_in_ready, 0);
  endtask

  initial begin
    logic [7:0] bytes[$];
    logic [31:0] c0;
    int unsigned len, n, rises, act;
    bit found;

    in_s.valid = 1'b0;
    in_s.data = 8'h00;
    out_s.ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {part_clk, part_test_se, part_test_tm, part_scan_in, busy, done, err,
                            in_s.ready, out_s.valid}, 0);
    check("reset_out_data", out_s.data, 8'h00);
    rst = 1'b0;

    // Load "101001"
    reseed('0, 8);
    bytes = '{8'h31, 8'h30, 8'h31, 8'h30, 8'h30, 8'h31};
    tx_q = bytes;
    run_op(1, 6, 0, -1);
    check_load("load6", bytes);

    // Unload 1011_0010 from an 8-bit chain
    reseed(32'hB2, 8);
    run_op(0, 8, 0, -1);
    check_unload("unload8", 32'hB2, 8, 8);

    // Unload with out_ready held low on bit 3
    c0 = 32'($urandom_range(0, 255));
    reseed(c0, 8);
    run_op(0, 8, 0, 3);
    check_unload("stall", c0, 8, 8);

    // Load with a bad character
    reseed('0, 8);
    bytes = '{8'h31, 8'h78, 8'h30};
    tx_q = bytes;
    run_op(1, 3, 0, -1);
    check_load("badchar", bytes);

    // Zero-length operations
    reseed('0, 8);
    run_op(1, 0, 0, -1);
    check("zero_load_done_cyc", done_cyc, 2);
    check("zero_load_edges", edge_cnt, 0);
    reseed(32'hFF, 8);
    run_op(0, 0, 0, -1);
    check("zero_unload_done_cyc", done_cyc, 2);
    check("zero_unload_rx", rx_q.size(), 0);

    // Randomized loads and unloads with random handshake gaps
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 12);
      bytes.delete();
      for (int unsigned i = 0; i < n; i++) begin
        if ($urandom_range(0, 5) == 0) bytes.push_back(8'($urandom_range(0, 255)));
        else bytes.push_back($urandom_range(0, 1) ? 8'h31 : 8'h30);
      end
      reseed('0, 24);
      tx_q = bytes;
      run_op(1, n, 1, -1);
      check_load($sformatf("rload%0d", k), bytes);

      len = $urandom_range(4, 20);
      n = $urandom_range(1, len);
      c0 = $urandom() & ((32'h1 << len) - 32'h1);
      reseed(c0, len);
      run_op(0, n, 1, -1);
      check_unload($sformatf("runload%0d", k), c0, len, n);
    end

    // Simultaneous starts, then reset during CLK_HI of bit 2
    reseed('0, 8);
    @(negedge clk);
    bit_count = 16'd5;
    load_start = 1'b1;
    unload_start = 1'b1;
    in_s.valid = 1'b1;
    in_s.data = 8'h78;
    out_s.ready = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    unload_start = 1'b0;
    check("both_start_is_load", {in_s.ready, out_s.valid}, 2'b10);
    rises = 0; found = 0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      if (part_clk && rises == 1 && !found) begin
        rises = 2;
        found = 1;
      end else if (part_clk && rises == 0) begin
        rises = 1;
        while (part_clk) @(negedge clk);
      end
    end
    check("reached_bit2_hi", found, 1);
    check("err_before_rst", err, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midop_reset_outputs", {part_clk, part_test_se, part_test_tm, part_scan_in, busy, done,
                                  err, in_s.ready, out_s.valid}, 0);
    check("midop_reset_out_data", out_s.data, 8'h00);
    act = 0;
    repeat (40) begin
      @(negedge clk);
      act += {31'b0, busy | done | part_clk | in_s.ready | out_s.valid};
    end
    check("no_resume", act, 0);
    in_s.valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
